// File: rtl/ni_injection_controller.sv
// ni_injection_controller: local-core packet injection sequencer feeding the router's local input port.
// Picks a free VC round-robin and emits labelled flits under per-VC on/off flow control.
package noc_params;
  localparam int VC_NUM = 2;
  localparam int DEST_ADDR_SIZE_X = 4;
  localparam int DEST_ADDR_SIZE_Y = 4;
  localparam int FLIT_DATA_SIZE = 16;
  localparam int HEAD_PAYLOAD_SIZE = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;
  localparam int VC_SIZE = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;
  typedef struct packed {
    logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
  } head_data_t;
  typedef union packed {
    head_data_t                head_data;
    logic [FLIT_DATA_SIZE-1:0] bt_pl;
  } flit_data_t;
  typedef struct packed {
    flit_label_t          flit_label;
    logic [VC_SIZE-1:0]   vc_id;
    flit_data_t           data;
  } flit_t;
endpackage

module ni_injection_controller #(
  parameter int VC_NUM  = noc_params::VC_NUM,
  parameter int PKT_MAX = 8,
  parameter int LEN_W   = $clog2(PKT_MAX + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  req_valid_i,
  output logic                                  req_ready_o,
  input  logic [noc_params::DEST_ADDR_SIZE_X-1:0] req_x_dest_i,
  input  logic [noc_params::DEST_ADDR_SIZE_Y-1:0] req_y_dest_i,
  input  logic [LEN_W-1:0]                      req_len_i,
  input  logic                                  data_valid_i,
  input  logic [noc_params::FLIT_DATA_SIZE-1:0] data_i,
  output logic                                  data_ready_o,
  input  logic [VC_NUM-1:0]                     on_off_i,
  input  logic [VC_NUM-1:0]                     vc_allocatable_i,
  output noc_params::flit_t                     flit_o,
  output logic                                  valid_flit_o,
  output logic                                  busy_o,
  output logic                                  error_o
);
  localparam int VW = noc_params::VC_SIZE;
  localparam int HP = noc_params::HEAD_PAYLOAD_SIZE;
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(PKT_MAX);
  localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);
  typedef enum logic [1:0] {IDLE, VC_SEL, SEND} state_t;
  state_t state_q, state_d;
  logic [VW-1:0] rr_ptr_q, rr_ptr_d, cur_vc_q, cur_vc_d, idx;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d;
  logic [noc_params::DEST_ADDR_SIZE_X-1:0] x_q, x_d;
  logic [noc_params::DEST_ADDR_SIZE_Y-1:0] y_q, y_d;
  noc_params::flit_t flit_q, flit_d;
  logic valid_q, valid_d, err_q, err_d, found, head;
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    cur_vc_d = cur_vc_q;
    cnt_d = cnt_q;
    len_d = len_q;
    x_d = x_q;
    y_d = y_q;
    flit_d = flit_q;
    valid_d = 1'b0;
    err_d = 1'b0;
    found = 1'b0;
    idx = '0;
    head = (cnt_q == '0);
    req_ready_o = (state_q == IDLE);
    data_ready_o = 1'b0;
    case (state_q)
      IDLE: if (req_valid_i) begin
        if (req_len_i == '0 || req_len_i > MAX_L) err_d = 1'b1;
        else begin
          x_d = req_x_dest_i;
          y_d = req_y_dest_i;
          len_d = req_len_i;
          state_d = VC_SEL;
        end
      end
      VC_SEL: for (int i = 0; i < VC_NUM; i++) begin
        idx = VW'((int'(rr_ptr_q) + i) % VC_NUM);
        if (!found && vc_allocatable_i[idx]) begin
          found = 1'b1;
          cur_vc_d = idx;
          state_d = SEND;
        end
      end
      SEND: begin
        data_ready_o = data_valid_i & on_off_i[cur_vc_q];
        if (data_ready_o) begin
          valid_d = 1'b1;
          flit_d.vc_id = cur_vc_q;
          flit_d.flit_label = head ? ((len_q == ONE_L) ? noc_params::HEADTAIL : noc_params::HEAD)
                                   : ((cnt_q == len_q - ONE_L) ? noc_params::TAIL : noc_params::BODY);
          if (head) flit_d.data.head_data = '{x_dest: x_q, y_dest: y_q, head_pl: data_i[HP-1:0]};
          else flit_d.data.bt_pl = data_i;
          cnt_d = cnt_q + ONE_L;
          if (cnt_q == len_q - ONE_L) begin
            state_d = IDLE;
            cnt_d = '0;
            rr_ptr_d = (cur_vc_q == VW'(VC_NUM - 1)) ? '0 : cur_vc_q + VW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      cur_vc_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      x_q <= '0;
      y_q <= '0;
      flit_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cur_vc_q <= cur_vc_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      x_q <= x_d;
      y_q <= y_d;
      flit_q <= flit_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  end
  assign flit_o = flit_q;
  assign valid_flit_o = valid_q;
  assign error_o = err_q;
  assign busy_o = (state_q != IDLE);
endmodule
